// File: rtl/level_tracker_if.sv
// Bundle of game-side inputs and display-side outputs for level_tracker.
// The master side drives the game inputs; the slave side is the tracker itself.
interface level_tracker_if #(
    parameter int unsigned LEVEL_W    = 7,
    parameter int unsigned LIVES_W    = 2,
    parameter int unsigned NUM_DIGITS = 2
);
    logic [3:0]              i_sw;
    logic                    frog_at_top;
    logic                    reset_level;
    logic [LIVES_W-1:0]      lives;
    logic [LEVEL_W-1:0]      level;
    logic [4*NUM_DIGITS-1:0] level_bcd;
    logic                    reset_frog;
    logic                    level_up;
    logic                    game_over;
    logic                    max_reached;

    modport master (
        output i_sw, frog_at_top, reset_level, lives,
        input  level, level_bcd, reset_frog, level_up, game_over, max_reached
    );

    modport slave (
        input  i_sw, frog_at_top, reset_level, lives,
        output level, level_bcd, reset_frog, level_up, game_over, max_reached
    );
endinterface

// File: rtl/level_tracker.sv
// Level/progress counter for the frog game: binary + incrementally kept BCD level,
// frog-reset pulse sequencing, game-over on lives exhaustion and a four-switch chord restart.
module level_tracker #(
    parameter int unsigned START_LEVEL     = 1,
    parameter int unsigned MAX_LEVEL       = 99,
    parameter int unsigned NUM_DIGITS      = 2,
    parameter int unsigned LEVEL_W         = 7,
    parameter int unsigned LIVES_W         = 2,
    parameter bit          WRAP            = 1'b0,
    parameter int unsigned CHORD_CYCLES    = 4,
    parameter int unsigned FROG_RST_CYCLES = 2
) (
    input logic           clk,
    input logic           reset,
    level_tracker_if.slave bus
);
    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned CHORD_W = $clog2(CHORD_CYCLES + 1);
    localparam int unsigned FRC_W   = $clog2(FROG_RST_CYCLES + 1);

    typedef enum logic [1:0] {PLAY, ADVANCE, OVER} state_t;

    // Add one to a BCD vector, rippling the decimal carry upward.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned n);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < n; i++) r = bcd_inc(r);
        return r;
    endfunction

    localparam logic [BCD_W-1:0]   START_BCD = to_bcd(START_LEVEL);
    localparam logic [LEVEL_W-1:0] START_LVL = LEVEL_W'(START_LEVEL);
    localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(MAX_LEVEL);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               reset_frog_q, reset_frog_d;
    logic               level_up_q, level_up_d;
    logic               game_over_q, game_over_d;
    logic [CHORD_W-1:0] chord_q, chord_d;
    logic [FRC_W-1:0]   frog_cnt_q, frog_cnt_d;
    logic               prev_top_q;

    logic chord_all_c;
    logic chord_fire_c;
    logic lives_out_c;
    logic top_rise_c;

    assign chord_all_c  = (bus.i_sw == 4'hF);
    assign chord_fire_c = chord_all_c && (chord_q == CHORD_W'(CHORD_CYCLES - 1));
    assign lives_out_c  = bus.reset_level && (bus.lives == '0);
    assign top_rise_c   = bus.frog_at_top && !prev_top_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        bcd_d        = bcd_q;
        reset_frog_d = reset_frog_q;
        level_up_d   = 1'b0;
        game_over_d  = game_over_q;
        frog_cnt_d   = frog_cnt_q;

        if (!chord_all_c) begin
            chord_d = '0;
        end else if (chord_q == CHORD_W'(CHORD_CYCLES)) begin
            chord_d = chord_q;
        end else begin
            chord_d = chord_q + CHORD_W'(1);
        end

        if (chord_fire_c) begin
            level_d      = START_LVL;
            bcd_d        = START_BCD;
            game_over_d  = 1'b0;
            state_d      = ADVANCE;
            reset_frog_d = 1'b1;
            frog_cnt_d   = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (lives_out_c) begin
                        state_d      = OVER;
                        game_over_d  = 1'b1;
                        reset_frog_d = 1'b1;
                    end else if (top_rise_c) begin
                        state_d      = ADVANCE;
                        reset_frog_d = 1'b1;
                        frog_cnt_d   = '0;
                        if (level_q < MAX_LVL) begin
                            level_d    = level_q + LEVEL_W'(1);
                            bcd_d      = bcd_inc(bcd_q);
                            level_up_d = 1'b1;
                        end else if (WRAP) begin
                            level_d    = START_LVL;
                            bcd_d      = START_BCD;
                            level_up_d = 1'b1;
                        end
                    end
                end
                ADVANCE: begin
                    if (lives_out_c) begin
                        state_d      = OVER;
                        game_over_d  = 1'b1;
                        reset_frog_d = 1'b1;
                    end else if (frog_cnt_q == FRC_W'(FROG_RST_CYCLES - 1)) begin
                        state_d      = PLAY;
                        reset_frog_d = 1'b0;
                    end else begin
                        frog_cnt_d = frog_cnt_q + FRC_W'(1);
                    end
                end
                OVER: begin
                    reset_frog_d = 1'b1;
                    game_over_d  = 1'b1;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PLAY;
            level_q      <= START_LVL;
            bcd_q        <= START_BCD;
            reset_frog_q <= 1'b0;
            level_up_q   <= 1'b0;
            game_over_q  <= 1'b0;
            chord_q      <= '0;
            frog_cnt_q   <= '0;
            prev_top_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            bcd_q        <= bcd_d;
            reset_frog_q <= reset_frog_d;
            level_up_q   <= level_up_d;
            game_over_q  <= game_over_d;
            chord_q      <= chord_d;
            frog_cnt_q   <= frog_cnt_d;
            prev_top_q   <= bus.frog_at_top;
        end
    end

    assign bus.level       = level_q;
    assign bus.level_bcd   = bcd_q;
    assign bus.reset_frog  = reset_frog_q;
    assign bus.level_up    = level_up_q;
    assign bus.game_over   = game_over_q;
    assign bus.max_reached = (level_q == MAX_LVL);
endmodule

// File: tb/tb_level_tracker.sv
// Bench for level_tracker: a WRAP=0 and a WRAP=1 instance share stimulus; a behavioural
// model feeds a per-cycle scoreboard, with table vectors and hand sequences on top.
module tb_level_tracker;
    localparam int MAXL   = 99;
    localparam int STARTL = 1;
    localparam int CHORD  = 4;
    localparam int FRST   = 2;
    localparam int S_PLAY = 0, S_ADV = 1, S_OVR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'h0;
    logic       top = 1'b0;
    logic       rl = 1'b0;
    logic [1:0] lives = 2'd3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    level_tracker_if #(.LEVEL_W(7), .LIVES_W(2), .NUM_DIGITS(2)) bus0 ();
    level_tracker_if #(.LEVEL_W(7), .LIVES_W(2), .NUM_DIGITS(2)) bus1 ();

    assign bus0.i_sw = sw;  assign bus0.frog_at_top = top;
    assign bus0.reset_level = rl;  assign bus0.lives = lives;
    assign bus1.i_sw = sw;  assign bus1.frog_at_top = top;
    assign bus1.reset_level = rl;  assign bus1.lives = lives;

    level_tracker #(.WRAP(1'b0)) u0 (.clk(clk), .reset(rst), .bus(bus0));
    level_tracker #(.WRAP(1'b1)) u1 (.clk(clk), .reset(rst), .bus(bus1));

    typedef struct {
        int st; int lvl; bit rf; bit lu; bit go; bit pt; int ch; int fc;
    } mdl_t;

    typedef struct packed {
        logic [6:0] lvl; logic [7:0] bcd; logic rf; logic lu; logic go; logic mx;
    } exp_t;

    typedef struct {
        logic [3:0] sw; logic top; logic rl; logic [1:0] lives; int ncyc;
        int lvl; logic go; logic rf; logic lu;
    } vec_t;

    mdl_t m0, m1;
    exp_t sb0[$];
    exp_t sb1[$];
    vec_t vt[$];

    // Behavioural model of one clock edge, driven by the current bench inputs.
    function automatic mdl_t mnext(mdl_t m, bit wrap);
        mdl_t n;
        bit rise, fire, out;
        n    = m;
        n.lu = 1'b0;
        n.pt = top;
        if (rst) begin
            n.st = S_PLAY; n.lvl = STARTL; n.rf = 1'b0; n.go = 1'b0;
            n.ch = 0; n.fc = 0; n.pt = 1'b0;
            return n;
        end
        rise = top && !m.pt;
        fire = (sw == 4'hF) && (m.ch == CHORD - 1);
        out  = rl && (lives == 2'd0);
        n.ch = (sw == 4'hF) ? ((m.ch < CHORD) ? m.ch + 1 : m.ch) : 0;
        if (fire) begin
            n.lvl = STARTL; n.go = 1'b0; n.st = S_ADV; n.rf = 1'b1; n.fc = 0;
        end else if (m.st == S_OVR) begin
            n.rf = 1'b1; n.go = 1'b1;
        end else if (out) begin
            n.st = S_OVR; n.go = 1'b1; n.rf = 1'b1;
        end else if (m.st == S_ADV) begin
            n.fc = m.fc + 1;
            if (n.fc == FRST) begin
                n.st = S_PLAY; n.rf = 1'b0;
            end
        end else if (rise) begin
            n.st = S_ADV; n.rf = 1'b1; n.fc = 0;
            if (m.lvl < MAXL) begin
                n.lvl = m.lvl + 1; n.lu = 1'b1;
            end else if (wrap) begin
                n.lvl = STARTL; n.lu = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.lvl = 7'(m.lvl);
        e.bcd = 8'(((m.lvl / 10) << 4) | (m.lvl % 10));
        e.rf  = m.rf;
        e.lu  = m.lu;
        e.go  = m.go;
        e.mx  = (m.lvl == MAXL);
        return e;
    endfunction

    task automatic cmp(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: got lvl=%0d bcd=%h rf=%b lu=%b go=%b mx=%b, expected lvl=%0d bcd=%h rf=%b lu=%b go=%b mx=%b",
                     name, $time, a.lvl, a.bcd, a.rf, a.lu, a.go, a.mx,
                     e.lvl, e.bcd, e.rf, e.lu, e.go, e.mx);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // One clock: push model expectations, advance, pop and compare both instances.
    task automatic step();
        mdl_t n0, n1;
        exp_t a;
        n0 = mnext(m0, 1'b0);
        n1 = mnext(m1, 1'b1);
        sb0.push_back(to_exp(n0));
        sb1.push_back(to_exp(n1));
        m0 = n0;
        m1 = n1;
        @(posedge clk);
        #1;
        a = {bus0.level, bus0.level_bcd, bus0.reset_frog, bus0.level_up, bus0.game_over, bus0.max_reached};
        cmp("sb_u0", a, sb0.pop_front());
        a = {bus1.level, bus1.level_bcd, bus1.reset_frog, bus1.level_up, bus1.game_over, bus1.max_reached};
        cmp("sb_u1", a, sb1.pop_front());
    endtask

    task automatic add(input logic [3:0] s, input logic t, input logic r, input logic [1:0] l,
                       input int n, input int lv, input logic g, input logic f, input logic u);
        vec_t v;
        v.sw = s; v.top = t; v.rl = r; v.lives = l; v.ncyc = n;
        v.lvl = lv; v.go = g; v.rf = f; v.lu = u;
        vt.push_back(v);
    endtask

    initial begin
        m0 = '{S_PLAY, STARTL, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        m1 = m0;

        //  sw    top   rl    lives n   lvl go    rf    lu
        add(4'h0, 1'b1, 1'b0, 2'd3, 1,  2, 1'b0, 1'b1, 1'b1);
        add(4'h0, 1'b1, 1'b0, 2'd3, 1,  2, 1'b0, 1'b1, 1'b0);
        add(4'h0, 1'b1, 1'b0, 2'd3, 1,  2, 1'b0, 1'b0, 1'b0);
        add(4'h0, 1'b1, 1'b0, 2'd3, 7,  2, 1'b0, 1'b0, 1'b0);
        add(4'h0, 1'b0, 1'b0, 2'd3, 1,  2, 1'b0, 1'b0, 1'b0);
        add(4'h0, 1'b0, 1'b1, 2'd2, 1,  2, 1'b0, 1'b0, 1'b0);
        add(4'h0, 1'b0, 1'b1, 2'd0, 1,  2, 1'b1, 1'b1, 1'b0);
        add(4'h0, 1'b1, 1'b0, 2'd0, 1,  2, 1'b1, 1'b1, 1'b0);
        add(4'h0, 1'b0, 1'b0, 2'd0, 1,  2, 1'b1, 1'b1, 1'b0);
        add(4'h0, 1'b1, 1'b0, 2'd0, 1,  2, 1'b1, 1'b1, 1'b0);
        add(4'hF, 1'b0, 1'b0, 2'd0, 3,  2, 1'b1, 1'b1, 1'b0);
        add(4'h0, 1'b0, 1'b0, 2'd0, 1,  2, 1'b1, 1'b1, 1'b0);
        add(4'hF, 1'b0, 1'b0, 2'd0, 3,  2, 1'b1, 1'b1, 1'b0);
        add(4'hF, 1'b0, 1'b0, 2'd0, 1,  1, 1'b0, 1'b1, 1'b0);
        add(4'hF, 1'b0, 1'b0, 2'd0, 1,  1, 1'b0, 1'b1, 1'b0);
        add(4'hF, 1'b0, 1'b0, 2'd0, 1,  1, 1'b0, 1'b0, 1'b0);
        add(4'hF, 1'b0, 1'b0, 2'd0, 16, 1, 1'b0, 1'b0, 1'b0);
        add(4'h0, 1'b0, 1'b0, 2'd3, 1,  1, 1'b0, 1'b0, 1'b0);

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        check_val("reset_level", int'(bus0.level), 1);
        check_val("reset_bcd", int'(bus0.level_bcd), 'h01);
        check_val("reset_flags", int'({bus0.reset_frog, bus0.level_up, bus0.game_over, bus0.max_reached}), 0);
        rst = 1'b0;
        step();

        foreach (vt[i]) begin
            sw = vt[i].sw; top = vt[i].top; rl = vt[i].rl; lives = vt[i].lives;
            repeat (vt[i].ncyc) step();
            check_val($sformatf("vec%0d_level", i), int'(bus0.level), vt[i].lvl);
            check_val($sformatf("vec%0d_game_over", i), int'(bus0.game_over), int'(vt[i].go));
            check_val($sformatf("vec%0d_reset_frog", i), int'(bus0.reset_frog), int'(vt[i].rf));
            check_val($sformatf("vec%0d_level_up", i), int'(bus0.level_up), int'(vt[i].lu));
        end
        sw = 4'h0; top = 1'b0; rl = 1'b0; lives = 2'd3;

        // Climb to MAX_LEVEL, spot-checking the decimal carries
        while (m0.lvl < MAXL) begin
            top = 1'b1;
            step();
            top = 1'b0;
            repeat (3) step();
            if (m0.lvl == 10) check_val("bcd_9_to_10", int'(bus0.level_bcd), 'h10);
            if (m0.lvl == 20) check_val("bcd_19_to_20", int'(bus0.level_bcd), 'h20);
        end
        check_val("at_max_bcd", int'(bus0.level_bcd), 'h99);
        check_val("at_max_reached", int'(bus0.max_reached), 1);

        // Top rise at MAX_LEVEL: saturate vs wrap
        top = 1'b1;
        step();
        check_val("sat_level", int'(bus0.level), 99);
        check_val("sat_no_level_up", int'(bus0.level_up), 0);
        check_val("sat_reset_frog", int'(bus0.reset_frog), 1);
        check_val("wrap_level_bcd", int'(bus1.level_bcd), 'h01);
        check_val("wrap_level_up", int'(bus1.level_up), 1);
        check_val("wrap_max_reached", int'(bus1.max_reached), 0);
        top = 1'b0;
        step();
        check_val("sat_reset_frog_2", int'(bus0.reset_frog), 1);
        step();
        check_val("sat_reset_frog_end", int'(bus0.reset_frog), 0);
        step();

        // Lives exhausted while in ADVANCE
        top = 1'b1;
        step();
        top = 1'b0; rl = 1'b1; lives = 2'd0;
        step();
        check_val("adv_to_over", int'(bus0.game_over), 1);
        rl = 1'b0; lives = 2'd3;
        step();
        check_val("over_hold_rf", int'(bus0.reset_frog), 1);

        // Reset during OVER
        rst = 1'b1;
        step();
        check_val("rst_over_level", int'(bus0.level), 1);
        check_val("rst_over_flags", int'({bus0.reset_frog, bus0.level_up, bus0.game_over}), 0);
        rst = 1'b0;
        step();

        // Reset mid-ADVANCE, then confirm PLAY accepts a rise
        top = 1'b1;
        step();
        check_val("pre_rst_adv_level", int'(bus0.level), 2);
        top = 1'b0; rst = 1'b1;
        step();
        check_val("rst_adv_level", int'(bus0.level), 1);
        check_val("rst_adv_rf", int'(bus0.reset_frog), 0);
        rst = 1'b0;
        step();
        top = 1'b1;
        step();
        check_val("post_rst_rise_level", int'(bus0.level), 2);
        check_val("post_rst_level_up", int'(bus0.level_up), 1);
        top = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
